// File: rtl/npc_ras_unit_pkg.sv
// Shared next-PC definitions: 3-bit operation codes and the reset vector.
package npc_ras_unit_pkg;

  // Next-PC operation codes driven by the decoder.
  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JUMP   = 3'b010,
    NPC_JAL    = 3'b011,
    NPC_JR     = 3'b100,
    NPC_RET    = 3'b101
  } npc_op_e;

  // PC value loaded on reset.
  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  // Byte step between sequential instructions.
  localparam logic [31:0] PC_STEP = 32'h0000_0004;

endpackage

// File: rtl/npc_ras_unit_ras_stack.sv
// Circular return-address stack. A push advances the top pointer and writes the
// new top; once full, a push silently overwrites the oldest entry and raises a
// one-cycle overflow pulse. A pop on an empty stack is ignored here (the caller
// flags it as a miss).
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_push_data,
  output logic [WIDTH-1:0]             o_top_data,
  output logic [$clog2(RAS_DEPTH):0]   o_count,
  output logic                         o_overflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic [PTR_W-1:0] w_ptr_inc;
  logic [PTR_W-1:0] w_ptr_dec;
  logic             w_full;

  assign w_ptr_inc  = r_ptr + PTR_W'(1);
  assign w_ptr_dec  = r_ptr - PTR_W'(1);
  assign w_full     = (r_count == CNT_W'(RAS_DEPTH));
  assign o_top_data = r_mem[r_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  // Pointer, occupancy and overflow pulse; reset discards any pending push/pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr      <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (i_push) begin
        r_ptr <= w_ptr_inc;
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end else if (i_pop && (r_count != {CNT_W{1'b0}})) begin
        r_ptr   <= w_ptr_dec;
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Entry storage; contents need no reset because occupancy gates their use.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_rst) begin
      r_mem[w_ptr_inc] <= i_push_data;
    end
  end

endmodule

// File: rtl/npc_ras_unit.sv
// Next-PC unit: PC register, next-PC selection and return-address cross-check.
// The RAS only predicts; the architectural return target is always rs_val, and
// disagreement is reported through a registered ras_miss pulse.
module npc_ras_unit
  import npc_ras_unit_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(PC_RESET)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_stall,
  input  logic [2:0]                 i_npc_op,
  input  logic                       i_branch_taken,
  input  logic [25:0]                i_imm,
  input  logic [WIDTH-1:0]           i_rs_val,
  input  logic                       i_redirect_valid,
  input  logic [WIDTH-1:0]           i_redirect_pc,
  output logic [WIDTH-1:0]           o_pc,
  output logic [WIDTH-1:0]           o_pc_plus4,
  output logic [WIDTH-1:0]           o_npc,
  output logic [$clog2(RAS_DEPTH):0] o_ras_count,
  output logic                       o_ras_miss,
  output logic                       o_ras_overflow
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic [WIDTH-1:0] r_pc;
  logic             r_miss;
  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_br_off;
  logic [WIDTH-1:0] w_jump;
  logic [WIDTH-1:0] w_npc;
  logic             w_update;
  logic             w_push;
  logic             w_pop;
  logic             w_miss_next;
  logic [WIDTH-1:0] w_top_data;
  logic [CNT_W-1:0] w_count;
  logic             w_overflow;

  assign w_pc_plus4 = r_pc + WIDTH'(PC_STEP);
  assign w_br_off   = {{(WIDTH-18){i_imm[15]}}, i_imm[15:0], 2'b00};
  // Upper bits above 28 come from pc+4; the mask form stays legal at WIDTH=28.
  assign w_jump     = (w_pc_plus4 & ~WIDTH'(28'hFFF_FFFF)) | WIDTH'({i_imm, 2'b00});

  // Next-PC selection: redirect wins, otherwise decode the operation.
  always_comb begin
    w_npc = w_pc_plus4;
    if (i_redirect_valid) begin
      w_npc = i_redirect_pc;
    end else begin
      case (npc_op_e'(i_npc_op))
        NPC_PLUS4: w_npc = w_pc_plus4;
        NPC_BRANCH: begin
          if (i_branch_taken) begin
            w_npc = w_pc_plus4 + w_br_off;
          end else begin
            w_npc = w_pc_plus4;
          end
        end
        NPC_JUMP: w_npc = w_jump;
        NPC_JAL:  w_npc = w_jump;
        NPC_JR:   w_npc = i_rs_val;
        NPC_RET:  w_npc = i_rs_val;
        default:  w_npc = w_pc_plus4;
      endcase
    end
  end

  // Stalls and redirects suppress all stack traffic.
  assign w_update    = !i_stall && !i_redirect_valid;
  assign w_push      = w_update && (i_npc_op == NPC_JAL);
  assign w_pop       = w_update && (i_npc_op == NPC_RET);
  assign w_miss_next = w_pop && ((w_count == {CNT_W{1'b0}}) || (w_top_data != i_rs_val));

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras_stack (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pc_plus4),
    .o_top_data  (w_top_data),
    .o_count     (w_count),
    .o_overflow  (w_overflow)
  );

  // PC register and registered miss pulse; reset beats stall and redirect.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc   <= RESET_PC;
      r_miss <= 1'b0;
    end else begin
      r_miss <= w_miss_next;
      if (!i_stall) begin
        r_pc <= w_npc;
      end
    end
  end

  assign o_pc           = r_pc;
  assign o_pc_plus4     = w_pc_plus4;
  assign o_npc          = w_npc;
  assign o_ras_count    = w_count;
  assign o_ras_miss     = r_miss;
  assign o_ras_overflow = w_overflow;

endmodule
